// File: rtl/ram1_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram1_bus_pkg
// Description : Shared types and constants for the Ram1 bus arbiter: FSM
//               state encoding, bus owner encoding, UART register map
//               defaults and UART status bit layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ram1_bus_pkg;

  // Default data-port addresses of the UART registers
  localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;

  // Bit positions inside the UART status word
  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_READY = 1;

  // Bus sequencer states
  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SRAM_RD     = 4'd1,
    SRAM_WR     = 4'd2,
    SRAM_WR_END = 4'd3,
    UART_WR     = 4'd4,
    UART_WR_END = 4'd5,
    UART_RD1    = 4'd6,
    UART_RD2    = 4'd7,
    ACK         = 4'd8
  } state_t;

  // Which CPU port owns the transaction in flight
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Build the 16-bit UART status word from the transmitter/receiver flags
  function automatic logic [15:0] uart_status(input logic tx_ready, input logic rx_ready);
    logic [15:0] s;
    s = 16'h0000;
    s[STAT_TX_READY] = tx_ready;
    s[STAT_RX_READY] = rx_ready;
    return s;
  endfunction

endpackage : ram1_bus_pkg
`default_nettype wire

// File: rtl/ram1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram1_bus_arbiter
// Description : Owns the shared Ram1 SRAM/UART bus. Arbitrates the CPU fetch
//               port (read-only) against the data port (fixed priority to
//               data), decodes the UART registers, and sequences the
//               multi-cycle SRAM and UART strobes. All strobes registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ram1_bus_arbiter
  import ram1_bus_pkg::*;
#(
  parameter logic [15:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR,
  parameter int          WR_CYCLES      = 1
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction fetch port
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  // data port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  // SRAM
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  // UART
  output logic        wrn,
  output logic        rdn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  // Write-strobe counter holds WR_CYCLES-1 down to 0
  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  state_t          r_state;
  owner_t          r_owner;
  logic            r_drive;
  logic [15:0]     r_dout;
  logic [CW-1:0]   r_wr_cnt;

  // Bus is driven only while a write data phase is active
  assign Ram1Data = r_drive ? r_dout : 16'hzzzz;

  // Arbitration, address decode and strobe sequencing with registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_drive   <= 1'b0;
      r_dout    <= 16'h0000;
      r_wr_cnt  <= '0;
      Ram1Addr  <= 18'd0;
      Ram1OE    <= 1'b1;
      Ram1WE    <= 1'b1;
      Ram1EN    <= 1'b1;
      wrn       <= 1'b1;
      rdn       <= 1'b1;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= 16'h0000;
      mem_rdata <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_owner  <= OWN_MEM;
            Ram1Addr <= {2'b00, mem_addr};
            r_dout   <= mem_wdata;
            if (mem_addr == UART_STAT_ADDR) begin
              // status is read-only; a write just completes
              if (!mem_we) mem_rdata <= uart_status(tbre & tsre, data_ready);
              mem_ack <= 1'b1;
              r_state <= ACK;
            end else if (mem_addr == UART_DATA_ADDR) begin
              if (mem_we) begin
                r_drive <= 1'b1;
                wrn     <= 1'b0;
                r_state <= UART_WR;
              end else begin
                rdn     <= 1'b0;
                r_state <= UART_RD1;
              end
            end else if (mem_we) begin
              r_drive  <= 1'b1;
              Ram1EN   <= 1'b0;
              Ram1WE   <= 1'b0;
              r_wr_cnt <= CW'(WR_CYCLES - 1);
              r_state  <= SRAM_WR;
            end else begin
              Ram1EN  <= 1'b0;
              Ram1OE  <= 1'b0;
              r_state <= SRAM_RD;
            end
          end else if (if_req) begin
            r_owner  <= OWN_IF;
            Ram1Addr <= {2'b00, if_addr};
            Ram1EN   <= 1'b0;
            Ram1OE   <= 1'b0;
            r_state  <= SRAM_RD;
          end
        end
        SRAM_RD: begin
          Ram1EN <= 1'b1;
          Ram1OE <= 1'b1;
          if (r_owner == OWN_MEM) begin
            mem_rdata <= Ram1Data;
            mem_ack   <= 1'b1;
          end else begin
            if_rdata <= Ram1Data;
            if_ack   <= 1'b1;
          end
          r_state <= ACK;
        end
        SRAM_WR: begin
          if (r_wr_cnt == '0) begin
            // release WE first; data and chip enable held for hold time
            Ram1WE  <= 1'b1;
            r_state <= SRAM_WR_END;
          end else begin
            r_wr_cnt <= r_wr_cnt - CW'(1);
          end
        end
        SRAM_WR_END: begin
          Ram1EN  <= 1'b1;
          r_drive <= 1'b0;
          mem_ack <= 1'b1;
          r_state <= ACK;
        end
        UART_WR: begin
          wrn     <= 1'b1;
          r_state <= UART_WR_END;
        end
        UART_WR_END: begin
          r_drive <= 1'b0;
          mem_ack <= 1'b1;
          r_state <= ACK;
        end
        UART_RD1: begin
          r_state <= UART_RD2;
        end
        UART_RD2: begin
          mem_rdata <= Ram1Data;
          rdn       <= 1'b1;
          mem_ack   <= 1'b1;
          r_state   <= ACK;
        end
        ACK: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_drive <= 1'b0;
          Ram1OE  <= 1'b1;
          Ram1WE  <= 1'b1;
          Ram1EN  <= 1'b1;
          wrn     <= 1'b1;
          rdn     <= 1'b1;
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : ram1_bus_arbiter
`default_nettype wire

// File: tb/tb_ram1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram1_bus_arbiter
// Description : Self-checking bench for ram1_bus_arbiter. Small SRAM and UART
//               models on the shared bus; table of data-port transactions
//               plus directed fetch, arbitration and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram1_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;
  logic        Ram1OE, Ram1WE, Ram1EN;
  logic        wrn, rdn;
  logic        tbre = 1'b0, tsre = 1'b0, data_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram [0:1023];
  logic [15:0] uart_val = 16'h0;

  ram1_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data),
    .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN),
    .wrn(wrn), .rdn(rdn), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );

  always #5 CLK = ~CLK;

  // SRAM drives on read, UART drives while rdn low
  assign Ram1Data = (!Ram1EN && !Ram1OE && Ram1WE) ? sram[Ram1Addr[9:0]] :
                    (!rdn ? uart_val : 16'hzzzz);

  // SRAM write while WE/EN asserted
  always @(negedge CLK) begin
    if (!Ram1EN && !Ram1WE) sram[Ram1Addr[9:0]] <= Ram1Data;
  end

  // Strobe exclusivity observed every cycle outside reset
  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if ((!Ram1EN && !rdn) || (!Ram1OE && !Ram1WE)) begin
        errors++;
        $display("FAIL strobe_excl: EN=%b rdn=%b OE=%b WE=%b required no EN/rdn or OE/WE overlap",
                 Ram1EN, rdn, Ram1OE, Ram1WE);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [2:0]  st;        // {tbre, tsre, data_ready}
    logic [15:0] uval;
    logic [15:0] exp_rdata; // checked on reads only
    int          exp_lat;
    int          exp_we_lo;
    int          exp_oe_lo;
    int          exp_wrn_lo;
    int          exp_rdn_lo;
    int          exp_en_lo; // -1: don't care
  } vec_t;

  vec_t vecs[9];

  task automatic run_mem(input vec_t v);
    int lat, we_lo, oe_lo, wrn_lo, rdn_lo, en_lo;
    logic [15:0] rd, bus_wrn;
    lat = 0; we_lo = 0; oe_lo = 0; wrn_lo = 0; rdn_lo = 0; en_lo = 0;
    rd = 16'h0; bus_wrn = 16'h0;
    {tbre, tsre, data_ready} = v.st;
    uart_val = v.uval;
    @(posedge CLK); #1;
    mem_req = 1'b1; mem_we = v.we; mem_addr = v.addr; mem_wdata = v.wdata;
    @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (!Ram1WE) we_lo++;
      if (!Ram1OE) oe_lo++;
      if (!Ram1EN) en_lo++;
      if (!rdn)    rdn_lo++;
      if (!wrn) begin wrn_lo++; bus_wrn = Ram1Data; end
      if (mem_ack) begin lat = k; rd = mem_rdata; break; end
    end
    mem_req = 1'b0;
    chk({v.name, "_lat"}, lat, v.exp_lat);
    if (!v.we) chk({v.name, "_rdata"}, {16'h0, rd}, {16'h0, v.exp_rdata});
    chk({v.name, "_we_lo"}, we_lo, v.exp_we_lo);
    chk({v.name, "_oe_lo"}, oe_lo, v.exp_oe_lo);
    chk({v.name, "_wrn_lo"}, wrn_lo, v.exp_wrn_lo);
    chk({v.name, "_rdn_lo"}, rdn_lo, v.exp_rdn_lo);
    if (v.exp_en_lo >= 0) chk({v.name, "_en_lo"}, en_lo, v.exp_en_lo);
    if (v.exp_wrn_lo > 0) chk({v.name, "_bus"}, {16'h0, bus_wrn}, {16'h0, v.wdata});
    @(negedge CLK);
    chk({v.name, "_ack_pulse"}, {31'h0, mem_ack}, 32'h0);
  endtask

  task automatic run_if(input logic [15:0] addr, input logic [15:0] exp_data);
    int lat, oe_lo;
    logic [15:0] rd;
    lat = 0; oe_lo = 0; rd = 16'h0;
    @(posedge CLK); #1;
    if_req = 1'b1; if_addr = addr;
    @(posedge CLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (!Ram1OE) oe_lo++;
      if (if_ack) begin lat = k; rd = if_rdata; break; end
    end
    if_req = 1'b0;
    chk("fetch_lat", lat, 2);
    chk("fetch_rdata", {16'h0, rd}, {16'h0, exp_data});
    chk("fetch_oe_lo", oe_lo, 1);
    @(negedge CLK);
    chk("fetch_ack_pulse", {31'h0, if_ack}, 32'h0);
  endtask

  initial begin
    int mlat, ilat, ack_seen;
    logic [15:0] mrd, ird;

    for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
    sram[10'h010] = 16'h1234;
    sram[10'h050] = 16'h7777;

    //        name     we    addr      wdata     st    uval      rdata     lat we oe wrn rdn en
    vecs[0] = '{"wr20",  1'b1, 16'h0020, 16'hBEEF, 3'b000, 16'h0000, 16'h0000, 3, 1, 0, 0, 0, -1};
    vecs[1] = '{"rd20",  1'b0, 16'h0020, 16'h0000, 3'b000, 16'h0000, 16'hBEEF, 2, 0, 1, 0, 0, 1};
    vecs[2] = '{"uwr",   1'b1, 16'hBF00, 16'h0041, 3'b000, 16'h0000, 16'h0000, 3, 0, 0, 1, 0, 0};
    vecs[3] = '{"st111", 1'b0, 16'hBF01, 16'h0000, 3'b111, 16'h0000, 16'h0003, 1, 0, 0, 0, 0, 0};
    vecs[4] = '{"urd",   1'b0, 16'hBF00, 16'h0000, 3'b111, 16'h005A, 16'h005A, 3, 0, 0, 0, 2, 0};
    vecs[5] = '{"st100", 1'b0, 16'hBF01, 16'h0000, 3'b100, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0};
    vecs[6] = '{"st110", 1'b0, 16'hBF01, 16'h0000, 3'b110, 16'h0000, 16'h0001, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{"stwr",  1'b1, 16'hBF01, 16'h5555, 3'b001, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0};
    vecs[8] = '{"rd10",  1'b0, 16'h0010, 16'h0000, 3'b000, 16'h0000, 16'h1234, 2, 0, 1, 0, 0, 1};

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_strobes", {25'h0, Ram1OE, Ram1WE, Ram1EN, wrn, rdn, if_ack, mem_ack}, 32'h7C);
    chk("rst_if_rdata", {16'h0, if_rdata}, 32'h0);
    chk("rst_mem_rdata", {16'h0, mem_rdata}, 32'h0);
    chk("rst_addr", {14'h0, Ram1Addr}, 32'h0);
    RST = 1'b0;

    // fetch of preloaded word
    run_if(16'h0010, 16'h1234);

    // data-port vector table
    for (int i = 0; i < 9; i++) run_mem(vecs[i]);

    // simultaneous requests: data first, one IDLE, then fetch
    mlat = 0; ilat = 0; mrd = 16'h0; ird = 16'h0;
    @(posedge CLK); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0050;
    if_req = 1'b1; if_addr = 16'h0010;
    @(posedge CLK);
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (mem_ack) begin mlat = k; mrd = mem_rdata; mem_req = 1'b0; end
      if (if_ack) begin ilat = k; ird = if_rdata; if_req = 1'b0; break; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    chk("arb_mem_lat", mlat, 2);
    chk("arb_mem_rdata", {16'h0, mrd}, 32'h7777);
    chk("arb_if_lat", ilat, 5);
    chk("arb_if_rdata", {16'h0, ird}, 32'h1234);

    // reset during SRAM_WR drops the write
    sram[10'h040] = 16'h0000;
    @(posedge CLK); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0040; mem_wdata = 16'hCAFE;
    @(posedge CLK); #2;
    chk("wr_in_progress", {31'h0, Ram1WE}, 32'h0);
    RST = 1'b1;
    #1;
    chk("rstmid_we", {31'h0, Ram1WE}, 32'h1);
    chk("rstmid_en", {31'h0, Ram1EN}, 32'h1);
    chk("rstmid_bus_released", {31'h0, (Ram1Data === 16'hCAFE)}, 32'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    ack_seen = 0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (mem_ack) ack_seen = 1;
    end
    chk("rstmid_no_ack", ack_seen, 0);
    chk("rstmid_sram_untouched", {16'h0, sram[10'h040]}, 32'h0);
    run_if(16'h0010, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule : tb_ram1_bus_arbiter
`default_nettype wire

// File: doc/ram1_bus_arbiter.md
Name: ram1_bus_arbiter

Overview:
- Owns the shared Ram1 bus: SRAM (Ram1Addr/Ram1Data/Ram1OE/Ram1WE/Ram1EN) plus the UART that shares Ram1Data via wrn/rdn.
- Arbitrates between the CPU's instruction-fetch port (read-only) and data-memory port (read/write).
- Sequences multi-cycle SRAM and UART strobes.
- Decodes UART data and status addresses on the data port.

Parameters:
- UART_DATA_ADDR, 16'hBF00, data-port address mapped to the UART data register.
- UART_STAT_ADDR, 16'hBF01, data-port address mapped to the UART status (read-only).
- WR_CYCLES, 1, number of cycles Ram1WE is held low on an SRAM write (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  16  fetch word address.
- if_rdata  out  16  fetch data; valid while if_ack=1, held until next fetch ack.
- if_ack  out  1  one-cycle completion pulse.
- mem_req  in  1  data request; held until mem_ack.
- mem_we  in  1  1=write, 0=read.
- mem_addr  in  16  data word address.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; valid while mem_ack=1, held until next data ack.
- mem_ack  out  1  one-cycle completion pulse.
- Ram1Addr  out  18  SRAM address, {2'b00, latched addr}.
- Ram1Data  inout  16  shared SRAM/UART data bus.
- Ram1OE, Ram1WE, Ram1EN  out  1 each  SRAM strobes, active-low.
- wrn, rdn  out  1 each  UART write/read strobes, active-low.
- tbre, tsre, data_ready  in  1 each  UART status inputs.

Behaviour:
- Reset (async, any state): state=IDLE; Ram1OE=Ram1WE=Ram1EN=1; wrn=rdn=1; Ram1Data=Z; if_ack=mem_ack=0; if_rdata=mem_rdata=0; Ram1Addr=0.
- Reset mid-transaction: the transaction is dropped with no ack.
- Arbitration in IDLE:
  - mem_req has fixed priority over if_req.
  - Address, we, wdata and owner are latched at acceptance.
  - Inputs are ignored outside IDLE.
- Data-port decode:
  - mem_addr == UART_DATA_ADDR selects UART read or write.
  - mem_addr == UART_STAT_ADDR selects a status read (writes to it complete with ack and no side effect).
  - Any other address selects SRAM.
- States: IDLE, SRAM_RD, SRAM_WR, SRAM_WR_END, UART_WR, UART_WR_END, UART_RD1, UART_RD2, ACK.
- Latency is counted from acceptance edge t; ack is high during cycle:
  - SRAM read: SRAM_RD (EN=0, OE=0, bus Z), data captured at end of SRAM_RD; ack at t+2.
  - SRAM write: SRAM_WR for WR_CYCLES cycles (EN=0, WE=0, bus driven), then SRAM_WR_END (WE=1, data still driven); ack at t+2+WR_CYCLES.
  - UART write: EN=1, bus driven; UART_WR wrn=0, UART_WR_END wrn=1 (data held); ack at t+3. Issued regardless of tbre/tsre; software polls status.
  - UART read: EN=1, bus Z; rdn=0 in UART_RD1 and UART_RD2, data captured at end of UART_RD2, rdn=1 in ACK; ack at t+3.
  - Status read: no bus activity; rdata = {14'b0, data_ready, tbre&tsre}; goes directly to ACK; ack at t+1.
- ACK state: the owner's ack=1 for exactly one cycle, all strobes inactive, bus Z, then IDLE.
  - A request still high in the following IDLE cycle starts a new transaction.
  - Back-to-back transactions therefore have one IDLE cycle between them.
- Bus contention:
  - Ram1Data is driven only in SRAM_WR, SRAM_WR_END, UART_WR and UART_WR_END.
  - Ram1EN=0 and rdn=0 are never asserted together.
  - OE and WE are never both 0.
- Simultaneous if_req and mem_req: the data port is served; fetch waits (no aging). Fetch is served on the next IDLE with mem_req=0.

Decomposition:
- Package ram1_bus_pkg holds:
  - the state enum;
  - UART_DATA_ADDR and UART_STAT_ADDR defaults;
  - status bit indices (STAT_TX_READY=0, STAT_RX_READY=1);
  - owner encoding (OWN_IF, OWN_MEM).
- No sub-module. The tri-state driver and FSM stay in one module.

Test Plan:
- Preload SRAM[0x0010]=16'h1234; if_req with if_addr=0x0010 -> if_ack at t+2 with if_rdata=16'h1234; Ram1OE=0 only in cycle t+1.
- mem write 0x0020 <- 16'hBEEF, then mem read 0x0020 -> Ram1WE low for 1 cycle, mem_ack at t+3; read returns 16'hBEEF at t+2.
- if_req and mem_req rise together (SRAM read) -> mem_ack first, then one IDLE cycle, then fetch accepted; if_ack 5 cycles after the mem acceptance edge.
- mem write to 0xBF00 with data 16'h0041 -> wrn low exactly 1 cycle, Ram1EN=1 throughout, bus=16'h0041 while wrn low, mem_ack at t+3.
- tbre=tsre=1, data_ready=1; read 0xBF01 -> mem_rdata=16'h0003 at t+1. Then UART drives 16'h005A; read 0xBF00 -> rdn low 2 cycles, mem_rdata=16'h005A.
- Assert RST during SRAM_WR -> same-cycle Ram1WE=1, Ram1Data=Z, no mem_ack; after release, a new fetch completes normally.
